rr_sel5_arbiter: RTL and testbench
==================================

Name: rr_sel5_arbiter

Overview:
- Round-robin arbiter and output register stage that sits directly upstream of the team's 5:1 3-bit mux.
- Accepts up to five 3-bit requesters and picks one per transaction, fairly.
- Drives the mux select code Sel (0..4) and holds it stable alongside a registered copy of the chosen data, under a valid/ready handshake toward the consumer.

Parameters:
- DW, 3, data width per channel and of Out.
- START_PTR, 0, channel index (0..4) that has highest priority after reset.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  5  per-channel request; req[i] = channel i (In1 = bit 0 ... In5 = bit 4) holds valid data.
- In1..In5  input  DW each  channel data, sampled on that channel's transfer.
- ack  output  5  per-channel ready, one-hot or zero. Channel i transfers on a rising edge where req[i] && ack[i].
- Sel  output  3  encoded grant, 3'b000..3'b100; drives the downstream mux select.
- Out  output  DW  registered copy of the granted channel's data.
- out_valid  output  1  Out/Sel hold a transaction.
- out_ready  input  1  consumer accepts Out on a rising edge where out_valid && out_ready.

Behaviour:
- Reset (async, rst_n low): Sel=3'b000, Out=0, out_valid=0, ptr=START_PTR, state=IDLE. ack is forced to 0 while rst_n is low.
- Any in-flight transaction is discarded on reset and no ack is issued. On rst_n deassertion, arbitration restarts from START_PTR.
- Two states:
  - IDLE: out_valid=0.
  - BUSY: out_valid=1; Sel and Out are frozen.
- Pick function (combinational, no latency): the first i with req[i]=1, scanning ptr, ptr+1, ... mod 5. Wrap-around goes 4 to 0.
- ack is nonzero only in these cases:
  - (IDLE) and any req is high, or
  - (BUSY && out_ready) and any req is high.
  - When nonzero, ack = onehot(pick). Otherwise ack=0.
- On a transfer from channel i:
  - Sel <= i, Out <= In(i+1), ptr <= (i+1) mod 5, state <= BUSY.
  - Latency is one clock from transfer to out_valid.
- BUSY && out_ready:
  - If any req is high, the next pick transfers in the same cycle. Back-to-back, no bubble, out_valid stays 1.
  - Otherwise out_valid <= 0 and state <= IDLE. Sel and Out keep their last values.
- BUSY && !out_ready: everything holds and ack=0. Requests queue upstream.
- Fairness:
  - A channel that has just been granted has lowest priority on the next pick.
  - With all five requesting continuously, grants go 0,1,2,3,4,0,...
  - Worst-case wait is 4 transactions.
- A requester may drop req in any cycle where it is not acked. The arbiter does not lock onto a channel before its transfer.
- The same channel requesting continuously while alone is granted every transaction.
- out_ready in IDLE is ignored.
- Sel never takes the values 3'b101..3'b111, so the downstream default branch is unreachable.
- All state is in flops reset by rst_n. No latches. Outputs Sel, Out and out_valid are registered; ack is combinational from state, ptr, req and out_ready.

Decomposition:
- Shared package rr_sel5_pkg holds:
  - localparam NCH=5 and SELW=3;
  - enum state_t {IDLE, BUSY};
  - function onehot5(idx) and function next_ptr(idx), which implements the mod-5 wrap.
- One sub-module: rr_pick5, the combinational rotating priority pick.
  - Inputs: req[4:0], ptr[2:0].
  - Outputs: found, idx[2:0].
  - Unit-testable standalone.

Test Plan:
- Reset checks:
  - Hold rst_n=0 with req=5'b11111 → ack=0, out_valid=0, Sel=000, Out=0.
  - Release, then req=5'b00100 with In3=3'b111 → ack=5'b00100 in the same cycle. Next cycle: Sel=3'b010, Out=3'b111, out_valid=1.
- Round-robin wrap: req=5'b11111 with out_ready=1 held → Sel sequence 000,001,010,011,100,000 on consecutive cycles, out_valid continuously 1, no bubble.
- Backpressure: in BUSY with Sel=001, hold out_ready=0 for 4 cycles with req=5'b10001 → ack=0 and Sel/Out stable. Raise out_ready → next grant is channel 4 (Sel=100), not channel 0.
- Drain to idle: single transfer from In1=3'b110, out_ready=1, req then 0 → out_valid falls after one cycle and Sel stays 000. out_ready pulses in IDLE cause no change.
- Mid-transaction reset: assert rst_n=0 asynchronously (between clock edges) while BUSY with Sel=011 → Sel, Out and out_valid clear immediately. After release with req=5'b11111, the first grant is START_PTR=0.
- Request withdrawal: in BUSY with out_ready=0, req[2] rises then falls before any ack, and req[3] is high → on out_ready the grant goes to channel 3. No ack ever reaches channel 2.

Source files
------------

// File: rtl/rr_sel5_pkg.sv
// Shared types and helpers for the five-channel round-robin select arbiter.
package rr_sel5_pkg;

  localparam int unsigned NCH  = 5;
  localparam int unsigned SELW = 3;

  typedef enum logic {IDLE, BUSY} state_t;

  function automatic logic [NCH-1:0] onehot5(input logic [SELW-1:0] idx);
    logic [NCH-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      v[i] = (idx == SELW'(i));
    end
    return v;
  endfunction

  function automatic logic [SELW-1:0] next_ptr(input logic [SELW-1:0] idx);
    return (idx >= SELW'(NCH - 1)) ? '0 : idx + SELW'(1);
  endfunction

endpackage

// File: rtl/rr_pick5.sv
// Rotating-priority pick: first requester at or after ptr, wrapping 4 -> 0.
module rr_pick5
  import rr_sel5_pkg::*;
(
  input  logic [4:0] req,
  input  logic [2:0] ptr,
  output logic       found,
  output logic [2:0] idx
);

  logic [SELW-1:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    // An out-of-range pointer falls back to channel 0 rather than reading X.
    cand  = (ptr < SELW'(NCH)) ? ptr : '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
      cand = next_ptr(cand);
    end
  end

endmodule

// File: rtl/rr_sel5_arbiter.sv
// Round-robin arbiter with registered select/data stage under valid/ready.
module rr_sel5_arbiter
  import rr_sel5_pkg::*;
#(
  parameter int unsigned DW        = 3,
  parameter int unsigned START_PTR = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [4:0]    req,
  input  logic [DW-1:0] In1,
  input  logic [DW-1:0] In2,
  input  logic [DW-1:0] In3,
  input  logic [DW-1:0] In4,
  input  logic [DW-1:0] In5,
  output logic [4:0]    ack,
  output logic [2:0]    Sel,
  output logic [DW-1:0] Out,
  output logic          out_valid,
  input  logic          out_ready
);

  state_t          state, state_n;
  logic [SELW-1:0] ptr, ptr_n;
  logic [SELW-1:0] sel_n;
  logic [DW-1:0]   out_n;
  logic            found;
  logic [SELW-1:0] pick;
  logic            take;
  logic [DW-1:0]   pick_data;

  rr_pick5 u_pick (
    .req   (req),
    .ptr   (ptr),
    .found (found),
    .idx   (pick)
  );

  always_comb begin
    case (pick)
      3'd0:    pick_data = In1;
      3'd1:    pick_data = In2;
      3'd2:    pick_data = In3;
      3'd3:    pick_data = In4;
      default: pick_data = In5;
    endcase
  end

  // ack is gated by rst_n so nothing transfers while reset is held.
  assign take = rst_n && found && ((state == IDLE) || out_ready);
  assign ack  = take ? onehot5(pick) : '0;

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    sel_n   = Sel;
    out_n   = Out;
    if (take) begin
      state_n = BUSY;
      ptr_n   = next_ptr(pick);
      sel_n   = pick;
      out_n   = pick_data;
    end else if ((state == BUSY) && out_ready) begin
      state_n = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= SELW'(START_PTR);
      Sel   <= '0;
      Out   <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      Sel   <= sel_n;
      Out   <= out_n;
    end
  end

  assign out_valid = (state == BUSY);

endmodule

// File: tb/tb_rr_sel5_arbiter.sv
// Directed bench for rr_sel5_arbiter with hand-computed expectations.
module tb_rr_sel5_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] req;
  logic [2:0] In1, In2, In3, In4, In5;
  logic [4:0] ack;
  logic [2:0] Sel;
  logic [2:0] Out;
  logic       out_valid;
  logic       out_ready;

  int unsigned total = 0;
  int unsigned bad   = 0;

  rr_sel5_arbiter #(.DW(3), .START_PTR(0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .In1       (In1),
    .In2       (In2),
    .In3       (In3),
    .In4       (In4),
    .In5       (In5),
    .ack       (ack),
    .Sel       (Sel),
    .Out       (Out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req = 5'b11111; out_ready = 1'b0;
    In1 = '0; In2 = '0; In3 = '0; In4 = '0; In5 = '0;

    // Reset holds everything quiet even with all requests high.
    repeat (2) tick();
    check("rst_ack",   ack, 5'b00000);
    check("rst_valid", out_valid, 1'b0);
    check("rst_sel",   Sel, 3'b000);
    check("rst_out",   Out, 3'b000);

    rst_n = 1'b1; req = 5'b00100; In3 = 3'b111;
    #1 check("first_ack", ack, 5'b00100);
    tick();
    check("first_sel",   Sel, 3'b010);
    check("first_out",   Out, 3'b111);
    check("first_valid", out_valid, 1'b1);
    req = '0; out_ready = 1'b1;
    tick();
    check("first_drain", out_valid, 1'b0);

    // Asynchronous reset pulse restarts the pointer at 0.
    #2 rst_n = 1'b0; #2 rst_n = 1'b1;
    In1 = 3'd1; In2 = 3'd2; In3 = 3'd3; In4 = 3'd4; In5 = 3'd5;
    req = 5'b11111; out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("rr_sel",   Sel, 32'(k % 5));
      check("rr_out",   Out, 32'(k % 5 + 1));
      check("rr_valid", out_valid, 1'b1);
    end
    tick();
    check("rr_sel7", Sel, 3'b001);

    // Backpressure with channels 0 and 4 waiting; ptr is 2.
    out_ready = 1'b0; req = 5'b10001;
    for (int k = 0; k < 4; k++) begin
      #1 check("bp_ack", ack, 5'b00000);
      tick();
      check("bp_sel", Sel, 3'b001);
      check("bp_out", Out, 3'd2);
      check("bp_valid", out_valid, 1'b1);
    end
    out_ready = 1'b1;
    #1 check("bp_release_ack", ack, 5'b10000);
    tick();
    check("bp_next_sel", Sel, 3'b100);
    check("bp_next_out", Out, 3'd5);

    req = '0;
    tick();
    check("idle_valid", out_valid, 1'b0);

    // Single transfer from In1 then drain; ptr is 0.
    In1 = 3'b110; req = 5'b00001;
    #1 check("drain_ack", ack, 5'b00001);
    tick();
    check("drain_sel", Sel, 3'b000);
    check("drain_out", Out, 3'b110);
    req = '0;
    tick();
    check("drain_valid", out_valid, 1'b0);
    check("drain_hold_sel", Sel, 3'b000);
    out_ready = 1'b0; tick();
    out_ready = 1'b1; tick();
    out_ready = 1'b0; tick();
    check("idle_or_valid", out_valid, 1'b0);
    check("idle_or_sel", Sel, 3'b000);
    check("idle_or_out", Out, 3'b110);

    // Reach Sel=3, then reset between edges; ptr is 1.
    req = 5'b01000;
    tick();
    check("mr_sel", Sel, 3'b011);
    #2 rst_n = 1'b0;
    #1;
    check("mr_sel_clr",   Sel, 3'b000);
    check("mr_out_clr",   Out, 3'b000);
    check("mr_valid_clr", out_valid, 1'b0);
    check("mr_ack",       ack, 5'b00000);
    rst_n = 1'b1; req = 5'b11111;
    #1 check("mr_restart_ack", ack, 5'b00001);
    tick();
    check("mr_restart_sel", Sel, 3'b000);

    // Channel 2 withdraws before being acked; ptr is 1 so it would win otherwise.
    req = 5'b01100;
    #1 check("wd_ack0", ack, 5'b00000);
    tick();
    req = 5'b01000;
    #1 check("wd_ack1", ack, 5'b00000);
    tick();
    out_ready = 1'b1;
    #1 check("wd_ack2", ack, 5'b01000);
    tick();
    check("wd_sel", Sel, 3'b011);
    check("wd_out", Out, 3'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
